// File: rtl/speed_gate_ctrl.sv
// -----------------------------------------------------------------------------
// speed_gate_ctrl
//
// Control FSM for the vehicle speed-check gate. Debounces the two roadside
// presence sensors and the two operator buttons, then sequences one speed
// measurement at a time:
//   sensor1 edge -> start timing -> sensor2 edge -> divide -> compare to limit
//   -> open the barrier and hold it, or keep it shut.
// It also aborts measurements that run too long.
//
// Ports
//   clk            system clock (only clock used)
//   reset_n        synchronous active-low reset
//   sensor1_raw    upstream presence sensor, asynchronous, 1 = vehicle present
//   sensor2_raw    downstream presence sensor, asynchronous
//   btn_open_raw   operator open button, asynchronous
//   btn_close_raw  operator close button, asynchronous
//   done           divider-complete pulse from the datapath
//   speed          divider result, valid while done = 1
//   init/count/cal/up/down/en/dis   registered datapath strobes
//   overspeed      sticky result flag for the last vehicle measured
//   timeout        one-cycle pulse when a measurement is aborted
//   busy           high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module speed_gate_ctrl #(
    parameter int SYS_FREQ     = 10000000,
    parameter int WIDTH_SPEED  = 14,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SPEED_LIMIT  = 60,
    parameter int TIMEOUT_MS   = 2000,
    parameter int HOLD_MS      = 3000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sensor1_raw,
    input  logic                   sensor2_raw,
    input  logic                   btn_open_raw,
    input  logic                   btn_close_raw,
    input  logic                   done,
    input  logic [WIDTH_SPEED-1:0] speed,
    output logic                   init,
    output logic                   count,
    output logic                   cal,
    output logic                   up,
    output logic                   down,
    output logic                   en,
    output logic                   dis,
    output logic                   overspeed,
    output logic                   timeout,
    output logic                   busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CYC_PER_MS = SYS_FREQ / 1000;
    localparam int PRESC_W    = $clog2(CYC_PER_MS + 1);
    localparam int MS_MAX     = (TIMEOUT_MS > HOLD_MS) ? TIMEOUT_MS : HOLD_MS;
    localparam int MS_W       = $clog2(MS_MAX + 1);
    localparam int DB_W       = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(CYC_PER_MS - 1);
    localparam logic [MS_W-1:0]        MS_SAT     = '1;
    localparam logic [MS_W-1:0]        MS_TMO     = MS_W'(TIMEOUT_MS);
    localparam logic [MS_W-1:0]        MS_HOLD    = MS_W'(HOLD_MS);
    localparam logic [DB_W-1:0]        DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [WIDTH_SPEED-1:0] LIMIT      = WIDTH_SPEED'(SPEED_LIMIT);

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer, stability counter, rise pulse.
    // Bit order: 0 = sensor1, 1 = sensor2, 2 = open button, 3 = close button.
    // ------------------------------------------------------------------
    logic [3:0] raw_in;
    logic [3:0] rise;

    assign raw_in = {btn_close_raw, btn_open_raw, sensor2_raw, sensor1_raw};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            logic            sync1_q;
            logic            sync2_q;
            logic            deb_q;
            logic            rise_q;
            logic [DB_W-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    rise_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_in[gi];
                    sync2_q <= sync1_q;
                    rise_q  <= 1'b0;
                    if (sync2_q == deb_q) begin
                        // Any return to the debounced level restarts the count.
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        // DEBOUNCE_CYC consecutive differing samples seen.
                        deb_q  <= sync2_q;
                        rise_q <= sync2_q;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + DB_W'(1);
                    end
                end
            end

            assign rise[gi] = rise_q;
        end
    endgenerate

    logic s1_rise, s2_rise, open_rise, close_rise;
    assign s1_rise    = rise[0];
    assign s2_rise    = rise[1];
    assign open_rise  = rise[2];
    assign close_rise = rise[3];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_MEASURE = 4'd2,
        S_CALC    = 4'd3,
        S_WAITD   = 4'd4,
        S_PASS    = 4'd5,
        S_HOLD    = 4'd6,
        S_CLOSE   = 4'd7,
        S_REJECT  = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic [PRESC_W-1:0] presc_q;
    logic [MS_W-1:0]    ms_q;

    // Transition events that also affect outputs.
    logic abort_evt;      // measurement timed out
    logic too_fast_evt;   // sensor2 arrived before the first ms elapsed
    logic judged_evt;     // divider result accepted this cycle
    logic judged_over;    // ... and it exceeded the limit

    logic init_q, count_q, cal_q, up_q, down_q, en_q, dis_q;
    logic overspeed_q, timeout_q, busy_q;
    logic init_d, count_d, cal_d, up_d, down_d, en_d, dis_d;
    logic overspeed_d, timeout_d, busy_d;

    // State register, output register and ms timer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            ms_q        <= '0;
            init_q      <= 1'b0;
            count_q     <= 1'b0;
            cal_q       <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            en_q        <= 1'b0;
            dis_q       <= 1'b0;
            overspeed_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            count_q     <= count_d;
            cal_q       <= cal_d;
            up_q        <= up_d;
            down_q      <= down_d;
            en_q        <= en_d;
            dis_q       <= dis_d;
            overspeed_q <= overspeed_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;

            // Timer restarts on every state entry so each state sees ms = 0
            // in its first cycle; the ms count saturates instead of wrapping.
            if (state_d != state_q) begin
                presc_q <= '0;
                ms_q    <= '0;
            end else if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                if (ms_q != MS_SAT) begin
                    ms_q <= ms_q + MS_W'(1);
                end
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        abort_evt    = 1'b0;
        too_fast_evt = 1'b0;
        judged_evt   = 1'b0;
        judged_over  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A simultaneous s2_rise is simply not looked at here.
                if (s1_rise) state_d = S_START;
            end
            S_START:  state_d = S_MEASURE;
            S_MEASURE: begin
                if (s2_rise) begin
                    if (ms_q == '0) begin
                        too_fast_evt = 1'b1;
                        state_d      = S_REJECT;
                    end else begin
                        state_d = S_CALC;
                    end
                end else if (ms_q >= MS_TMO) begin
                    abort_evt = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_CALC:   state_d = S_WAITD;
            S_WAITD: begin
                if (done) begin
                    judged_evt  = 1'b1;
                    judged_over = (speed > LIMIT);
                    state_d     = judged_over ? S_REJECT : S_PASS;
                end
            end
            S_PASS:   state_d = S_HOLD;
            S_HOLD: begin
                // Manual close ends the hold without a dis strobe.
                if (close_rise) begin
                    state_d = S_IDLE;
                end else if (ms_q >= MS_HOLD) begin
                    state_d = S_CLOSE;
                end
            end
            S_CLOSE:  state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: strobes are decoded from the next state so that, once
    // registered, each is high exactly while the FSM occupies its state.
    always_comb begin
        init_d      = (state_d == S_START);
        count_d     = (state_d == S_MEASURE);
        cal_d       = (state_d == S_CALC);
        en_d        = (state_d == S_PASS);
        dis_d       = (state_d == S_CLOSE) || (state_d == S_REJECT);
        busy_d      = (state_d != S_IDLE);
        timeout_d   = abort_evt;
        // Close wins when both buttons rise together.
        down_d      = close_rise;
        up_d        = open_rise && !close_rise;
        overspeed_d = overspeed_q;
        if (too_fast_evt) begin
            overspeed_d = 1'b1;
        end else if (judged_evt) begin
            overspeed_d = judged_over;
        end
    end

    assign init      = init_q;
    assign count     = count_q;
    assign cal       = cal_q;
    assign up        = up_q;
    assign down      = down_q;
    assign en        = en_q;
    assign dis       = dis_q;
    assign overspeed = overspeed_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_speed_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_speed_gate_ctrl
//
// Scoreboard bench: each scenario predicts, from the gate's timing rules, the
// sequence of strobes (with cycle numbers) it should produce and queues them.
// A monitor watching the outputs on the falling edge pops and compares one
// entry per observed strobe (a run of count is reported once, with its
// length). Anything left over, or anything unexpected, is a failure.
// -----------------------------------------------------------------------------
module tb_speed_gate_ctrl;

    localparam int D     = 4;        // DEBOUNCE_CYC
    localparam int CPM   = 10;       // cycles per ms at SYS_FREQ = 10000
    localparam int TMO   = 50;       // TIMEOUT_MS
    localparam int HOLD  = 20;       // HOLD_MS
    localparam int LIMIT = 60;       // SPEED_LIMIT
    localparam int LAT   = 2 + D;    // raw edge to rise pulse

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s1 = 1'b0, s2 = 1'b0, bo = 1'b0, bc = 1'b0, done = 1'b0;
    logic [13:0] speed = '0;
    logic        init, count, cal, up, down, en, dis, overspeed, timeout, busy;

    speed_gate_ctrl #(
        .SYS_FREQ    (10000),
        .WIDTH_SPEED (14),
        .DEBOUNCE_CYC(D),
        .SPEED_LIMIT (LIMIT),
        .TIMEOUT_MS  (TMO),
        .HOLD_MS     (HOLD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sensor1_raw  (s1),
        .sensor2_raw  (s2),
        .btn_open_raw (bo),
        .btn_close_raw(bc),
        .done         (done),
        .speed        (speed),
        .init         (init),
        .count        (count),
        .cal          (cal),
        .up           (up),
        .down         (down),
        .en           (en),
        .dis          (dis),
        .overspeed    (overspeed),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    at;    // cycle the strobe (or count run) starts
        int    tol;   // allowed deviation of at / len
        int    len;   // run length for count, -1 otherwise
        int    ovs;   // required overspeed level, -1 = don't care
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_on = 1'b0;

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic void push(input string n, input int at, input int tol,
                                 input int len, input int ovs);
        ev_t e;
        e.name = n; e.at = at; e.tol = tol; e.len = len; e.ovs = ovs;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input string n, input int at, input int len);
        ev_t e;
        bit  bad;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got strobe at cycle %0d len %0d, required none",
                     n, at, len);
            return;
        end
        e   = exp_q.pop_front();
        bad = (e.name != n) || (adiff(at, e.at) > e.tol) ||
              (e.len >= 0 && adiff(len, e.len) > e.tol) ||
              (e.ovs >= 0 && overspeed !== e.ovs[0]);
        if (bad) begin
            n_bad++;
            $display("FAIL strobe_%s: got %s at %0d len %0d ovs %b, required %s at %0d(+-%0d) len %0d ovs %0d",
                     e.name, n, at, len, overspeed, e.name, e.at, e.tol, e.len, e.ovs);
        end else begin
            $display("ok   %-7s at cycle %0d len %0d ovs %b", n, at, len, overspeed);
        end
    endfunction

    // Monitor: one observation per strobe; count runs reported when they end.
    bit cnt_run = 1'b0;
    int cnt_start = 0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (count === 1'b1) begin
                if (!cnt_run) begin
                    cnt_run   = 1'b1;
                    cnt_start = cyc;
                end
            end else if (cnt_run) begin
                cnt_run = 1'b0;
                observe("count", cnt_start, cyc - cnt_start);
            end
            if (init    === 1'b1) observe("init",    cyc, -1);
            if (cal     === 1'b1) observe("cal",     cyc, -1);
            if (up      === 1'b1) observe("up",      cyc, -1);
            if (down    === 1'b1) observe("down",    cyc, -1);
            if (en      === 1'b1) observe("en",      cyc, -1);
            if (dis     === 1'b1) observe("dis",     cyc, -1);
            if (timeout === 1'b1) observe("timeout", cyc, -1);
        end
    end

    function automatic void check_bit(input string n, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", n, got, want);
        end else begin
            $display("ok   %s = %b", n, got);
        end
    endfunction

    function automatic void check_all_zero(input string n);
        logic [9:0] v;
        v = {init, count, cal, up, down, en, dis, overspeed, timeout, busy};
        n_cmp++;
        if (v !== 10'b0) begin
            n_bad++;
            $display("FAIL %s: got outputs %b, required all 0", n, v);
        end else begin
            $display("ok   %s outputs all 0", n);
        end
    endfunction

    function automatic void drain_check(input string n);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: got %0d strobes missing (next %s at %0d), required 0",
                     n, exp_q.size(), exp_q[0].name, exp_q[0].at);
            exp_q.delete();
        end
    endfunction

    // One vehicle. transit < 0: no sensor2 (timeout). close_rel >= 0: press
    // close that many cycles after entering HOLD.
    task automatic run_meas(input int transit, input int spd, input int close_rel);
        int k, m, r2, c, h, b, t_end;
        k = cyc;
        m = k + LAT + 2;                 // first cycle of count
        c = -1; b = -1;
        push("init", k + LAT + 1, 0, -1, -1);
        if (transit < 0) begin
            push("count",   m,               1, TMO * CPM + 1, -1);
            push("timeout", m + TMO * CPM + 1, 1, -1, -1);
            t_end = m + TMO * CPM + 1;
        end else begin
            r2 = k + transit + LAT;      // s2_rise cycle
            push("count", m, 0, r2 - m + 1, -1);
            if ((r2 - m) / CPM == 0) begin
                push("dis", r2 + 1, 0, -1, 1);
                t_end = r2 + 1;
            end else begin
                c = r2 + 1;
                push("cal", c, 0, -1, -1);
                if (spd <= LIMIT) begin
                    push("en", c + 6, 0, -1, 0);
                    h = c + 7;
                    if (close_rel >= 0) begin
                        b = h + close_rel;
                        push("down", b + LAT + 1, 0, -1, -1);
                        t_end = b + LAT + 1;
                    end else begin
                        push("dis", h + HOLD * CPM, 1, -1, 0);
                        t_end = h + HOLD * CPM + 1;
                    end
                end else begin
                    push("dis", c + 6, 0, -1, 1);
                    t_end = c + 6;
                end
            end
        end
        $display("run  transit=%0d speed=%0d close=%0d start=%0d", transit, spd, close_rel, k);
        for (int t = k; t <= t_end + 30; t++) begin
            s1    = (t < k + 10);
            s2    = (transit >= 0) && (t >= k + transit) && (t < k + transit + 10);
            done  = (c >= 0) && (t == c + 5);
            speed = done ? 14'(spd) : 14'($urandom);
            bc    = (b >= 0) && (t >= b) && (t < b + 8);
            @(negedge clk);
        end
        s1 = 1'b0; s2 = 1'b0; done = 1'b0; bc = 1'b0;
        drain_check("run");
        check_bit("busy_idle", busy, 1'b0);
    endtask

    task automatic btn_test(input bit op, input bit cl);
        int k;
        k = cyc;
        if (cl)      push("down", k + LAT + 1, 0, -1, -1);
        else if (op) push("up",   k + LAT + 1, 0, -1, -1);
        $display("btn  open=%0d close=%0d start=%0d", op, cl, k);
        for (int t = k; t <= k + 40; t++) begin
            bo = op && (t < k + 8);
            bc = cl && (t < k + 8);
            @(negedge clk);
        end
        drain_check("btn");
    endtask

    task automatic glitch_test();
        int k;
        k = cyc;
        $display("glitch 3-cycle sensor1 start=%0d", k);
        for (int t = k; t <= k + 40; t++) begin
            s1 = (t < k + 3);
            @(negedge clk);
        end
        drain_check("glitch");
        check_bit("busy_glitch", busy, 1'b0);
    endtask

    task automatic reset_test();
        int k, m, r;
        k = cyc;
        m = k + LAT + 2;
        r = m + 50;
        push("init", k + LAT + 1, 0, -1, -1);
        push("count", m, 0, r - m + 1, -1);
        $display("rst  reset during measure at %0d", r);
        for (int t = k; t <= r; t++) begin
            s1      = (t < k + 10);
            reset_n = (t != r);
            @(negedge clk);
        end
        reset_n = 1'b1;
        check_all_zero("reset_mid");
        repeat (30) @(negedge clk);
        drain_check("reset");
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset_n = 1'b1;
        mon_on  = 1'b1;
        repeat (5) @(negedge clk);

        run_meas(240, 60, -1);     // legal pass at the limit
        run_meas(240, 61, -1);     // overspeed
        run_meas(240, 60, -1);     // clears overspeed
        run_meas(-1, 0, -1);       // timeout
        run_meas(12, 40, -1);      // shortest transit that still divides
        run_meas(5, 0, -1);        // sub-ms transit
        reset_test();              // also clears the overspeed left above
        run_meas(240, 60, -1);
        glitch_test();
        btn_test(1'b1, 1'b1);
        btn_test(1'b1, 1'b0);
        run_meas(100, 30, 20);     // close button during HOLD

        for (int i = 0; i < 10; i++) begin
            int kind, spd;
            kind = $urandom_range(0, 3);
            spd  = $urandom_range(0, 1) ? $urandom_range(0, LIMIT) : $urandom_range(LIMIT + 1, 16383);
            case (kind)
                0:       run_meas($urandom_range(12, 450), $urandom_range(0, LIMIT), -1);
                1:       run_meas($urandom_range(12, 450), spd, -1);
                2:       run_meas($urandom_range(2, 11), 0, -1);
                default: run_meas(-1, 0, -1);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
